dct_2d_sequencer: RTL and testbench

Sequences one shared 8-point 1-D DCT butterfly (5-stage pipeline, 8x32-bit in/out, no valid or stall) through a full 8x8 2-D DCT. Pass 1 streams 8 input rows through the butterfly into a transpose buffer. Pass 2 re-issues the 8 columns and captures the results in a result buffer. The block then presents the 8 coefficient rows to downstream (entropy/quant) over a valid/ready handshake. It sits between the pixel-block fetcher and quantisation in the encoder.

---
 rtl/dct_pkg.sv | 28 ++
 rtl/dct_transpose_buf.sv | 35 +++
 rtl/dct_2d_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dct_2d_sequencer.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared types and constants for the 8x8 2-D DCT sequencer.
//   DCT_N          - transform size (8 points per row/column)
//   DCT_DATA_W     - default sample/coefficient width
//   DCT_BF_LATENCY - default butterfly pipeline depth
//   state_e        - sequencer phases
//   tag_t          - valid tag travelling alongside a butterfly vector
package dct_pkg;

  localparam int DCT_N          = 8;
  localparam int DCT_DATA_W     = 32;
  localparam int DCT_BF_LATENCY = 5;

  typedef logic signed [DCT_DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    LOAD,
    DRAIN_R,
    COLS,
    DRAIN_C,
    OUTPUT
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } tag_t;

endpackage

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: 8x8 word array, written one row at a time and read one
// column at a time. Used both as the inter-pass transpose store and as the
// coefficient store.
//   CLOCK   - rising-edge clock
//   wr_en   - write wr_data into row wr_row this cycle
//   wr_row  - row index for the write
//   wr_data - 8 words, element i lands in column i
//   rd_col  - column index for the read
//   rd_data - element i = word at [i][rd_col] (combinational)
// Contents are never reset: every location is rewritten before it is read.
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W
) (
  input  logic                         CLOCK,
  input  logic                         wr_en,
  input  logic [2:0]                   wr_row,
  input  logic [DCT_N-1:0][DATA_W-1:0] wr_data,
  input  logic [2:0]                   rd_col,
  output logic [DCT_N-1:0][DATA_W-1:0] rd_data
);

  logic [DCT_N-1:0][DCT_N-1:0][DATA_W-1:0] mem;

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wr_row] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DCT_N; i++) rd_data[i] = mem[i][rd_col];
  end

endmodule

// File: rtl/dct_2d_sequencer.sv
// dct_2d_sequencer: drives one shared 8-point 1-D DCT butterfly through a full
// 8x8 2-D DCT. Pass 1 sends the 8 input rows, pass 2 re-sends the 8 columns of
// the intermediate result, then the 8 coefficient rows go downstream.
//   CLOCK, RESET        - clock, asynchronous active-low reset
//   IN_VALID/IN_READY   - input row handshake, IN_DATA[0] = leftmost sample
//   OUT_VALID/OUT_READY - output row handshake, OUT_DATA[u] = F[OUT_ROW][u]
//   OUT_ROW, OUT_LAST   - current coefficient row, high with row 7
//   BF_DATA/BF_OUT_DATA - vector to / result from the butterfly
//   BUSY                - low only when idle in LOAD with no row taken
//
// Handshakes: a row transfers on a rising edge where valid and ready are both
// high. Valid, once raised, holds its data stable until that transfer; ready
// never depends combinationally on valid of the same interface.
module dct_2d_sequencer
  import dct_pkg::*;
#(
  parameter int BF_LATENCY = DCT_BF_LATENCY,
  parameter int DATA_W     = DCT_DATA_W
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [DCT_N-1:0][DATA_W-1:0] IN_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [DCT_N-1:0][DATA_W-1:0] OUT_DATA,
  output logic [2:0]                   OUT_ROW,
  output logic                         OUT_LAST,
  output logic [DCT_N-1:0][DATA_W-1:0] BF_DATA,
  input  logic [DCT_N-1:0][DATA_W-1:0] BF_OUT_DATA,
  output logic                         BUSY
);

  state_e                       state, state_nxt;
  logic [2:0]                   cnt, cnt_nxt;   // rows in / columns out / rows out
  logic                         rdy_en;         // keeps IN_READY low until first clock after reset
  tag_t                         tag_pipe [BF_LATENCY];
  tag_t                         tag_in, tag_tail;
  logic                         in_acc, t_wr, r_wr;
  logic [DCT_N-1:0][DATA_W-1:0] t_col, r_row;

  assign tag_tail = tag_pipe[BF_LATENCY-1];
  assign in_acc   = IN_VALID && IN_READY;
  assign BUSY     = !(state == LOAD && cnt == 3'd0);

  // Pass-1 results only ever emerge in LOAD/DRAIN_R, pass-2 results only in
  // COLS/DRAIN_C, because each drain waits for the last tag to leave the pipe.
  assign t_wr = tag_tail.valid && (state == LOAD || state == DRAIN_R);
  assign r_wr = tag_tail.valid && (state == COLS || state == DRAIN_C);

  // State register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state  <= LOAD;
      cnt    <= 3'd0;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rdy_en <= 1'b1;
    end
  end

  // Next-state logic. The 3-bit counter wraps to 0 exactly when a phase ends,
  // so every phase starts counting from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOAD: begin
        if (in_acc) begin
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) state_nxt = DRAIN_R;
        end
      end
      DRAIN_R: begin
        if (tag_tail.valid && tag_tail.idx == 3'd7) state_nxt = COLS;
      end
      COLS: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) state_nxt = DRAIN_C;
      end
      DRAIN_C: begin
        if (tag_tail.valid && tag_tail.idx == 3'd7) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (OUT_READY) begin
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    IN_READY  = 1'b0;
    BF_DATA   = '0;
    tag_in    = '0;
    OUT_VALID = 1'b0;
    OUT_ROW   = 3'd0;
    OUT_LAST  = 1'b0;
    OUT_DATA  = '0;
    case (state)
      LOAD: begin
        IN_READY = rdy_en;
        if (IN_VALID && rdy_en) begin
          BF_DATA      = IN_DATA;
          tag_in.valid = 1'b1;
          tag_in.idx   = cnt;
        end
      end
      COLS: begin
        BF_DATA      = t_col;
        tag_in.valid = 1'b1;
        tag_in.idx   = cnt;
      end
      OUTPUT: begin
        OUT_VALID = 1'b1;
        OUT_ROW   = cnt;
        OUT_LAST  = (cnt == 3'd7);
        OUT_DATA  = r_row;
      end
      default: ;
    endcase
  end

  // Valid-tag pipe mirrors the butterfly depth so each result is written to
  // the right row/column exactly when it appears on BF_OUT_DATA.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < BF_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < BF_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // T: row r of pass 1 stored at row r; column c read back for pass 2.
  dct_transpose_buf #(.DATA_W(DATA_W)) u_t_buf (
    .CLOCK   (CLOCK),
    .wr_en   (t_wr),
    .wr_row  (tag_tail.idx),
    .wr_data (BF_OUT_DATA),
    .rd_col  (cnt),
    .rd_data (t_col)
  );

  // R is held transposed: the pass-2 result for column c is stored at row c,
  // so reading column v yields coefficient row F[v][*].
  dct_transpose_buf #(.DATA_W(DATA_W)) u_r_buf (
    .CLOCK   (CLOCK),
    .wr_en   (r_wr),
    .wr_row  (tag_tail.idx),
    .wr_data (BF_OUT_DATA),
    .rd_col  (cnt),
    .rd_data (r_row)
  );

endmodule

// File: tb/tb_dct_2d_sequencer.sv
module tb_dct_2d_sequencer;

  localparam int W = 8 * 32;
  typedef logic [7:0][31:0]       row_t;
  typedef logic [7:0][7:0][31:0]  blk_t;

  logic CLOCK     = 1'b0;
  logic RESET     = 1'b1;
  logic IN_VALID  = 1'b0;
  logic OUT_READY = 1'b0;
  row_t IN_DATA   = '0;
  logic IN_READY, OUT_VALID, OUT_LAST, BUSY;
  logic [2:0] OUT_ROW;
  row_t OUT_DATA, BF_DATA, BF_OUT_DATA;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  dct_2d_sequencer dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_DATA     (IN_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_DATA    (OUT_DATA),
    .OUT_ROW     (OUT_ROW),
    .OUT_LAST    (OUT_LAST),
    .BF_DATA     (BF_DATA),
    .BF_OUT_DATA (BF_OUT_DATA),
    .BUSY        (BUSY)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- butterfly model (fixed-point 8-point DCT, 5 stages) ----
  function automatic longint mag(input int m);
    case (m)
      0: return 2048; 1: return 2009; 2: return 1892; 3: return 1703;
      4: return 1448; 5: return 1138; 6: return 784;  7: return 400;
      default: return 0;
    endcase
  endfunction

  // 2048*cos(m*pi/16), symmetric rounding so constant inputs give exact zeros
  function automatic longint cos_w(input int m);
    int mm;
    mm = m % 32;
    if (mm <= 8)       return mag(mm);
    else if (mm <= 16) return -mag(16 - mm);
    else if (mm <= 24) return -mag(mm - 16);
    else               return mag(32 - mm);
  endfunction

  function automatic row_t bf_func(input row_t x);
    row_t   y;
    longint acc;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++)
        acc += longint'($signed(x[n])) * ((k == 0) ? 64'sd1448 : cos_w((2 * n + 1) * k));
      y[k] = 32'(acc >>> 12);
    end
    return y;
  endfunction

  row_t bf_pipe [5];
  always @(posedge CLOCK) begin
    bf_pipe[0] <= bf_func(BF_DATA);
    for (int i = 1; i < 5; i++) bf_pipe[i] <= bf_pipe[i-1];
  end
  assign BF_OUT_DATA = bf_pipe[4];

  // ---------------- reference model: rows, then columns ----------------
  function automatic blk_t dct2d(input blk_t x);
    blk_t t, r;
    row_t col, res;
    for (int rr = 0; rr < 8; rr++) t[rr] = bf_func(x[rr]);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 8; i++) col[i] = t[i][c];
      res = bf_func(col);
      for (int v = 0; v < 8; v++) r[v][c] = res[v];
    end
    return r;
  endfunction

  function automatic row_t random_row();
    row_t r;
    for (int i = 0; i < 8; i++) r[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
    return r;
  endfunction

  function automatic blk_t random_blk();
    blk_t b;
    for (int i = 0; i < 8; i++) b[i] = random_row();
    return b;
  endfunction

  function automatic blk_t const_blk(input int val);
    blk_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) b[i][j] = 32'(val);
    return b;
  endfunction

  task automatic push_block(input blk_t b);
    for (int v = 0; v < 8; v++) exp_q.push_back(b[v]);
  endtask

  // ---------------- driver tasks ----------------
  // mode 0: valid every cycle, 1: toggling 1,0,1,0, 2: random
  task automatic drive_block(input blk_t blk, input int mode,
                             output int first_acc, output int ready_low, output int timed_out);
    int   r, guard;
    logic v;
    bit   ph;
    r = 0; guard = 0; ph = 0;
    first_acc = -1; ready_low = 0;
    while (r < 8 && guard < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = !ph;
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph = !ph;
      IN_VALID = v;
      IN_DATA  = v ? blk[r] : random_row();
      if (v && IN_READY === 1'b1) begin
        if (r == 0) first_acc = cyc;
        r++;
      end else if (IN_READY !== 1'b1 && r > 0) begin
        ready_low++;
      end
      @(posedge CLOCK); #1;
      guard++;
    end
    IN_VALID  = 1'b0;
    IN_DATA   = random_row();
    timed_out = (r < 8);
  endtask

  // mode 0: ready always, 1: random ready. Optional stall of stall_len cycles
  // on row stall_row, recording any output change during it.
  task automatic collect_block(input int mode, input int stall_row, input int stall_len,
                               output blk_t got, output logic [7:0][2:0] got_row,
                               output logic [7:0] got_last, output int first_vld,
                               output int last_hs, output int unstable, output int timed_out);
    int         v, guard, stalled;
    logic       rdy;
    row_t       snap;
    logic [2:0] snap_row;
    v = 0; guard = 0; stalled = 0;
    got = '0; got_row = '0; got_last = '0;
    first_vld = -1; last_hs = -1; unstable = 0;
    snap = '0; snap_row = '0;
    while (v < 8 && guard < 400) begin
      rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stalled > 0 && stalled < stall_len) begin
        if (OUT_VALID !== 1'b1 || OUT_DATA !== snap || OUT_ROW !== snap_row) unstable++;
        stalled++;
        rdy = 1'b0;
      end else if (stalled == 0 && stall_len > 0 && OUT_VALID === 1'b1 &&
                   OUT_ROW === 3'(stall_row)) begin
        snap = OUT_DATA; snap_row = OUT_ROW;
        stalled = 1;
        rdy = 1'b0;
      end
      OUT_READY = rdy;
      if (OUT_VALID === 1'b1) begin
        if (first_vld < 0) first_vld = cyc;
        if (rdy) begin
          got[v] = OUT_DATA; got_row[v] = OUT_ROW; got_last[v] = OUT_LAST;
          if (v == 7) last_hs = cyc;
          v++;
        end
      end
      @(posedge CLOCK); #1;
      guard++;
    end
    OUT_READY = 1'b0;
    timed_out = (v < 8);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 RESET = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    checks++;
    if ({IN_READY, OUT_VALID, OUT_LAST, BUSY} !== 4'b0 || OUT_ROW !== 3'd0 ||
        BF_DATA !== '0 || OUT_DATA !== '0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b last=%b busy=%b row=%0d bf=%h out=%h, want all zero",
               IN_READY, OUT_VALID, OUT_LAST, BUSY, OUT_ROW, BF_DATA, OUT_DATA);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clock: IN_READY=%b want 0", IN_READY);
    end
    @(posedge CLOCK); #1;
    checks++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_clock: IN_READY=%b BUSY=%b want 1 0", IN_READY, BUSY);
    end
  endtask

  task automatic test_zero_block();
    blk_t blk, got;
    logic [7:0][2:0] grow;
    logic [7:0] glast;
    logic [W-1:0] e;
    int x, fv, lh, un, dto, cto, rl;
    blk = '0;
    drive_block(blk, 0, x, rl, dto);
    push_block(dct2d(blk));
    collect_block(0, 0, 0, got, grow, glast, fv, lh, un, cto);
    checks++;
    if (dto != 0 || cto != 0) begin
      errors++; $display("FAIL zero_timeout: in=%0d out=%0d want 0 0", dto, cto);
    end
    checks++;
    if (fv - x != 26) begin
      errors++; $display("FAIL zero_first_valid_latency: %0d want 26", fv - x);
    end
    checks++;
    if (lh - x != 33) begin
      errors++; $display("FAIL zero_last_row_cycle: %0d want 33", lh - x);
    end
    for (int v = 0; v < 8; v++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[v] !== row_t'(e) || got[v] !== '0) begin
        errors++; $display("FAIL zero_row%0d: %h want %h", v, got[v], e);
      end
      checks++;
      if (grow[v] !== 3'(v) || glast[v] !== (v == 7)) begin
        errors++; $display("FAIL zero_row_last%0d: row=%0d last=%b want %0d %b", v, grow[v], glast[v], v, v == 7);
      end
    end
  endtask

  task automatic test_constant();
    blk_t blk, got;
    logic [7:0][2:0] grow;
    logic [7:0] glast;
    logic [W-1:0] e;
    row_t exp_col, exp_r0;
    int x, fv, lh, un, dto, cto, rl, guard, c;
    blk = const_blk(8);
    drive_block(blk, 0, x, rl, dto);
    guard = 0;
    while (cyc < x + 12 && guard < 50) begin
      @(posedge CLOCK); #1; guard++;
    end
    // cycles x+12 (drain) .. x+21 (drain): columns 0..7 in between
    for (int k = 0; k < 10; k++) begin
      c = k - 1;
      for (int i = 0; i < 8; i++) exp_col[i] = (c == 0) ? 32'd22 : 32'd0;
      checks++;
      if (BF_DATA !== exp_col) begin
        errors++; $display("FAIL const_bf_col%0d: %h want %h", c, BF_DATA, exp_col);
      end
      @(posedge CLOCK); #1;
    end
    push_block(dct2d(blk));
    collect_block(0, 0, 0, got, grow, glast, fv, lh, un, cto);
    checks++;
    if (dto != 0 || cto != 0) begin
      errors++; $display("FAIL const_timeout: in=%0d out=%0d want 0 0", dto, cto);
    end
    exp_r0 = '0; exp_r0[0] = 32'd62;
    for (int v = 0; v < 8; v++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[v] !== row_t'(e) || got[v] !== ((v == 0) ? exp_r0 : row_t'('0))) begin
        errors++; $display("FAIL const_row%0d: %h want %h", v, got[v], e);
      end
    end
  endtask

  task automatic test_bubbles();
    blk_t blk, got;
    logic [7:0][2:0] grow;
    logic [7:0] glast;
    logic [W-1:0] e;
    int x, fv, lh, un, dto, cto, rl;
    blk = const_blk(8);
    drive_block(blk, 1, x, rl, dto);
    checks++;
    if (rl != 0 || dto != 0) begin
      errors++; $display("FAIL bubble_ready_low: low_cycles=%0d timeout=%0d want 0 0", rl, dto);
    end
    push_block(dct2d(blk));
    collect_block(0, 0, 0, got, grow, glast, fv, lh, un, cto);
    for (int v = 0; v < 8; v++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[v] !== row_t'(e) || cto != 0) begin
        errors++; $display("FAIL bubble_row%0d: %h want %h", v, got[v], e);
      end
    end
  endtask

  task automatic test_stall();
    blk_t blk, got;
    logic [7:0][2:0] grow;
    logic [7:0] glast;
    logic [W-1:0] e;
    int x, fv, lh, un, dto, cto, rl;
    blk = random_blk();
    drive_block(blk, 0, x, rl, dto);
    push_block(dct2d(blk));
    collect_block(0, 3, 10, got, grow, glast, fv, lh, un, cto);
    checks++;
    if (un != 0 || cto != 0) begin
      errors++; $display("FAIL stall_stable: changes=%0d timeout=%0d want 0 0", un, cto);
    end
    checks++;
    if (lh - x != 43) begin
      errors++; $display("FAIL stall_last_row_cycle: %0d want 43", lh - x);
    end
    for (int v = 0; v < 8; v++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[v] !== row_t'(e) || grow[v] !== 3'(v)) begin
        errors++; $display("FAIL stall_row%0d: row=%0d %h want %0d %h", v, grow[v], got[v], v, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    blk_t blk, got;
    logic [7:0][2:0] grow;
    logic [7:0] glast;
    logic [W-1:0] e;
    row_t exp_r0;
    int x, fv, lh, un, dto, cto, rl, guard;
    blk = random_blk();
    drive_block(blk, 0, x, rl, dto);
    guard = 0;
    while (cyc < x + 15 && guard < 50) begin
      @(posedge CLOCK); #1; guard++;
    end
    RESET = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({IN_READY, OUT_VALID, OUT_LAST, BUSY} !== 4'b0 || OUT_ROW !== 3'd0 ||
          BF_DATA !== '0 || OUT_DATA !== '0) begin
        errors++;
        $display("FAIL mid_reset_values%0d: ready=%b valid=%b last=%b busy=%b row=%0d bf=%h, want all zero",
                 k, IN_READY, OUT_VALID, OUT_LAST, BUSY, OUT_ROW, BF_DATA);
      end
      @(posedge CLOCK); #1;
    end
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    blk = const_blk(8);
    drive_block(blk, 0, x, rl, dto);
    push_block(dct2d(blk));
    collect_block(0, 0, 0, got, grow, glast, fv, lh, un, cto);
    exp_r0 = '0; exp_r0[0] = 32'd62;
    for (int v = 0; v < 8; v++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[v] !== row_t'(e) || got[v] !== ((v == 0) ? exp_r0 : row_t'('0)) || cto != 0) begin
        errors++; $display("FAIL mid_reset_row%0d: %h want %h", v, got[v], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    blk_t b1, b2, g1, g2;
    logic [7:0][2:0] r1, r2;
    logic [7:0] l1, l2;
    logic [W-1:0] e;
    int x1, x2, fv1, lh1, fv2, lh2, un, dto1, dto2, cto1, cto2, rl;
    b1 = '0;
    b2 = const_blk(8);
    drive_block(b1, 0, x1, rl, dto1);
    push_block(dct2d(b1));
    fork
      collect_block(0, 0, 0, g1, r1, l1, fv1, lh1, un, cto1);
      drive_block(b2, 0, x2, rl, dto2);
    join
    push_block(dct2d(b2));
    collect_block(0, 0, 0, g2, r2, l2, fv2, lh2, un, cto2);
    checks++;
    if (x2 != lh1 + 1 || dto2 != 0) begin
      errors++; $display("FAIL b2b_second_accept: cycle %0d want %0d", x2, lh1 + 1);
    end
    for (int v = 0; v < 8; v++) begin
      e = exp_q.pop_front();
      checks++;
      if (g1[v] !== row_t'(e) || cto1 != 0) begin
        errors++; $display("FAIL b2b_first_row%0d: %h want %h", v, g1[v], e);
      end
    end
    for (int v = 0; v < 8; v++) begin
      e = exp_q.pop_front();
      checks++;
      if (g2[v] !== row_t'(e) || cto2 != 0) begin
        errors++; $display("FAIL b2b_second_row%0d: %h want %h", v, g2[v], e);
      end
    end
  endtask

  task automatic test_random();
    blk_t blk, got;
    logic [7:0][2:0] grow;
    logic [7:0] glast;
    logic [W-1:0] e;
    int x, fv, lh, un, dto, cto, rl;
    for (int n = 0; n < 3; n++) begin
      blk = random_blk();
      drive_block(blk, 2, x, rl, dto);
      push_block(dct2d(blk));
      collect_block(1, 0, 0, got, grow, glast, fv, lh, un, cto);
      checks++;
      if (dto != 0 || cto != 0) begin
        errors++; $display("FAIL random%0d_timeout: in=%0d out=%0d want 0 0", n, dto, cto);
      end
      for (int v = 0; v < 8; v++) begin
        e = exp_q.pop_front();
        checks++;
        if (got[v] !== row_t'(e) || grow[v] !== 3'(v) || glast[v] !== (v == 7)) begin
          errors++; $display("FAIL random%0d_row%0d: row=%0d last=%b %h want %h", n, v, grow[v], glast[v], got[v], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_constant();
    test_bubbles();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
